// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for a word-organised data memory port.
// Accepts load/store requests, issues aligned word beats with byte strobes,
// and reassembles and extends load data. A watchdog bounds every beat.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (split misaligned accesses
// into two aligned beats; when undefined, misaligned accesses fault).
module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] DataAddress,
  input  logic [XLEN-1:0] WriteData,
  output logic [XLEN-1:0] ReadData,
  output logic            LoadValid,
  output logic            Stall,
  output logic            Fault,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
);

  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    RESP  = 2'd2
`ifdef LSU_MISALIGN_SPLIT_EN
    , BEAT2 = 2'd3
`endif
  } state_t;

  state_t state_reg, state_next;

  // Captured request
  logic [1:0]      off_reg;
  logic [2:0]      funct3_reg;
  logic            we_reg;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [XLEN-1:0] wdata_reg;
  logic            split_reg;
  logic [XLEN-1:0] buf_reg;
`endif

  // Beat outputs and response registers
  logic            mem_en_reg, mem_we_reg;
  logic [XLEN-1:0] mem_addr_reg, mem_wdata_reg;
  logic [3:0]      mem_wstrb_reg;
  logic [XLEN-1:0] read_data_reg;
  logic            load_valid_reg, fault_reg;
  logic [WD_W-1:0] wd_reg;

  // Control strobes from the FSM
  logic stall_c, accept, reject, finish, timeout, waiting;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic to_beat2;
`endif
  logic req_illegal, req_split;
  logic [XLEN-1:0] load_result;

  // Byte-lane mask for size code sz placed at byte offset off (8 lanes wide)
  function automatic logic [7:0] lane_strb(input logic [1:0] sz, input logic [1:0] off);
    logic [7:0] m;
    case (sz)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << off;
  endfunction

  // Store data shifted into its byte lanes across a double word
  function automatic logic [2*XLEN-1:0] lane_data(input logic [XLEN-1:0] d, input logic [1:0] off);
    return {{XLEN{1'b0}}, d} << {off, 3'b000};
  endfunction

  // Sign or zero extension of the right-aligned load bytes
  function automatic logic [XLEN-1:0] extend(input logic [2:0] f, input logic [XLEN-1:0] w);
    case (f)
      3'b000:  return {{(XLEN-8){w[7]}}, w[7:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, w[7:0]};
      3'b001:  return {{(XLEN-16){w[15]}}, w[15:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Request legality and split detection
  always_comb begin
    req_illegal = 1'b0;
    req_split   = 1'b0;
    if (MemRead && MemWrite)
      req_illegal = 1'b1;
    else if (MemRead && (Funct3[1:0] == 2'b11 || Funct3 == 3'b110))
      req_illegal = 1'b1;
    else if (MemWrite && Funct3 > 3'b010)
      req_illegal = 1'b1;
    case (Funct3[1:0])
      2'b01:   req_split = (DataAddress[1:0] == 2'b11);
      2'b10:   req_split = (DataAddress[1:0] != 2'b00);
      default: req_split = 1'b0;
    endcase
`ifndef LSU_MISALIGN_SPLIT_EN
    // Without splitting, any access that crosses natural alignment faults
    case (Funct3[1:0])
      2'b01:   if (DataAddress[0]) req_illegal = 1'b1;
      2'b10:   if (DataAddress[1:0] != 2'b00) req_illegal = 1'b1;
      default: ;
    endcase
`endif
  end

  // Reassemble load bytes from the last beat (and the merge buffer if split)
  always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
    if (split_reg)
      load_result = extend(funct3_reg, XLEN'({mem_rdata, buf_reg} >> {off_reg, 3'b000}));
    else
      load_result = extend(funct3_reg, mem_rdata >> {off_reg, 3'b000});
`else
    load_result = extend(funct3_reg, mem_rdata >> {off_reg, 3'b000});
`endif
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic, stall and control strobes
  always_comb begin
    state_next = state_reg;
    stall_c    = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    finish     = 1'b0;
    timeout    = 1'b0;
    waiting    = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    to_beat2   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        stall_c = MemRead | MemWrite;
        if (MemRead | MemWrite) begin
          if (req_illegal) begin
            reject     = 1'b1;
            state_next = RESP;
          end else begin
            accept     = 1'b1;
            state_next = BEAT1;
          end
        end
      end
      BEAT1: begin
        stall_c = 1'b1;
        if (mem_ready) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_reg) begin
            to_beat2   = 1'b1;
            state_next = BEAT2;
          end else begin
            finish     = 1'b1;
            state_next = RESP;
          end
`else
          finish     = 1'b1;
          state_next = RESP;
`endif
        end else if (wd_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout    = 1'b1;
          state_next = RESP;
        end else begin
          waiting = 1'b1;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BEAT2: begin
        stall_c = 1'b1;
        if (mem_ready) begin
          finish     = 1'b1;
          state_next = RESP;
        end else if (wd_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout    = 1'b1;
          state_next = RESP;
        end else begin
          waiting = 1'b1;
        end
      end
`endif
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, beat registers, merge buffer, watchdog and response pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      off_reg        <= '0;
      funct3_reg     <= '0;
      we_reg         <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      wdata_reg      <= '0;
      split_reg      <= 1'b0;
      buf_reg        <= '0;
`endif
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_wstrb_reg  <= '0;
      read_data_reg  <= '0;
      load_valid_reg <= 1'b0;
      fault_reg      <= 1'b0;
      wd_reg         <= '0;
    end else begin
      load_valid_reg <= 1'b0;
      fault_reg      <= 1'b0;
      read_data_reg  <= '0;
      if (accept) begin
        off_reg       <= DataAddress[1:0];
        funct3_reg    <= Funct3;
        we_reg        <= MemWrite;
`ifdef LSU_MISALIGN_SPLIT_EN
        wdata_reg     <= WriteData;
        split_reg     <= req_split;
`endif
        mem_en_reg    <= 1'b1;
        mem_we_reg    <= MemWrite;
        mem_addr_reg  <= {DataAddress[XLEN-1:2], 2'b00};
        mem_wstrb_reg <= MemWrite ? 4'(lane_strb(Funct3[1:0], DataAddress[1:0])) : 4'b0000;
        mem_wdata_reg <= MemWrite ? XLEN'(lane_data(WriteData, DataAddress[1:0])) : '0;
        wd_reg        <= '0;
      end
      if (reject) begin
        fault_reg <= 1'b1;
      end
      if (waiting) begin
        wd_reg <= wd_reg + 1'b1;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (to_beat2) begin
        // Second beat: next word, remaining low lanes, remaining upper bytes
        buf_reg       <= mem_rdata;
        mem_addr_reg  <= mem_addr_reg + XLEN'(4);
        mem_wstrb_reg <= we_reg ? 4'(lane_strb(funct3_reg[1:0], off_reg) >> 4) : 4'b0000;
        mem_wdata_reg <= we_reg ? XLEN'(lane_data(wdata_reg, off_reg) >> XLEN) : '0;
        wd_reg        <= '0;
      end
`endif
      if (finish || timeout) begin
        mem_en_reg    <= 1'b0;
        mem_we_reg    <= 1'b0;
        mem_addr_reg  <= '0;
        mem_wdata_reg <= '0;
        mem_wstrb_reg <= '0;
        wd_reg        <= '0;
      end
      if (finish && !we_reg) begin
        load_valid_reg <= 1'b1;
        read_data_reg  <= load_result;
      end
      if (timeout) begin
        fault_reg <= 1'b1;
      end
    end
  end

  assign Stall     = stall_c;
  assign ReadData  = read_data_reg;
  assign LoadValid = load_valid_reg;
  assign Fault     = fault_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: table-driven directed vectors against a
// small word memory responder with programmable wait states, plus
// hand-written watchdog-timeout and mid-transaction reset sequences.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] DataAddress, WriteData;
  logic [31:0] ReadData;
  logic        LoadValid, Stall, Fault;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .DataAddress(DataAddress), .WriteData(WriteData),
    .ReadData(ReadData), .LoadValid(LoadValid), .Stall(Stall), .Fault(Fault),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory model contents
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h4433_2211;
      32'h0000_0104: return 32'h8877_6655;
      32'h0000_0200: return 32'h8012_3456;
      32'hFFFF_FFFC: return 32'hBBAA_9988;
      32'h0000_0000: return 32'h3322_1100;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // Beat log filled by the responder
  int          cur_waits = 0;
  int          beat_n    = 0;
  logic [31:0] log_addr  [4];
  logic        log_we    [4];
  logic [3:0]  log_strb  [4];
  logic [31:0] log_wdata [4];

  // Memory responder: each beat completes after cur_waits wait cycles
  initial begin
    int wcnt;
    wcnt      = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge CLK);
      if (mem_en) begin
        if (wcnt >= cur_waits) begin
          mem_ready = 1'b1;
          mem_rdata = mem_read(mem_addr);
          if (beat_n < 4) begin
            log_addr[beat_n]  = mem_addr;
            log_we[beat_n]    = mem_we;
            log_strb[beat_n]  = mem_wstrb;
            log_wdata[beat_n] = mem_wdata;
          end
          beat_n++;
          wcnt = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = '0;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        wcnt      = 0;
      end
    end
  end

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          waits;
    int          stall;
    int          nbeats;
    logic        fault;
    logic        valid;
    logic [31:0] rdata;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] d1;
    logic [31:0] a2;
    logic [3:0]  s2;
    logic [31:0] d2;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int waits, input int stall,
                              input int nbeats, input logic fault, input logic valid,
                              input logic [31:0] rdata,
                              input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1,
                              input logic [31:0] a2, input logic [3:0] s2, input logic [31:0] d2);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.waits = waits; v.stall = stall; v.nbeats = nbeats; v.fault = fault;
    v.valid = valid; v.rdata = rdata; v.a1 = a1; v.s1 = s1; v.d1 = d1;
    v.a2 = a2; v.s2 = s2; v.d2 = d2;
    vecs.push_back(v);
  endfunction

  // Apply one request starting just after a negedge; returns at the negedge after RESP
  task automatic run_vec(input vec_t v);
    int   stall_cnt;
    bit   done;
    logic r_fault, r_valid;
    logic [31:0] r_data;
    beat_n      = 0;
    cur_waits   = v.waits;
    MemRead     = v.rd;
    MemWrite    = v.wr;
    Funct3      = v.f3;
    DataAddress = v.addr;
    WriteData   = v.wd;
    #1;
    stall_cnt = Stall ? 1 : 0;
    done      = 1'b0;
    r_fault   = 1'b0;
    r_valid   = 1'b0;
    r_data    = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (Stall) stall_cnt++;
      else begin
        done    = 1'b1;
        r_fault = Fault;
        r_valid = LoadValid;
        r_data  = ReadData;
      end
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    chk({v.name, " resp_reached"}, 32'(done), 32'd1);
    chk({v.name, " stall_cycles"}, stall_cnt, v.stall);
    chk({v.name, " fault"}, 32'(r_fault), 32'(v.fault));
    chk({v.name, " load_valid"}, 32'(r_valid), 32'(v.valid));
    chk({v.name, " read_data"}, r_data, v.rdata);
    chk({v.name, " beats"}, beat_n, v.nbeats);
    if (v.nbeats >= 1 && beat_n >= 1) begin
      chk({v.name, " b1_addr"}, log_addr[0], v.a1);
      chk({v.name, " b1_we"}, 32'(log_we[0]), 32'(v.wr));
      chk({v.name, " b1_strb"}, 32'(log_strb[0]), 32'(v.s1));
      chk({v.name, " b1_wdata"}, log_wdata[0], v.d1);
    end
    if (v.nbeats >= 2 && beat_n >= 2) begin
      chk({v.name, " b2_addr"}, log_addr[1], v.a2);
      chk({v.name, " b2_we"}, 32'(log_we[1]), 32'(v.wr));
      chk({v.name, " b2_strb"}, 32'(log_strb[1]), 32'(v.s2));
      chk({v.name, " b2_wdata"}, log_wdata[1], v.d2);
    end
    @(negedge CLK);
    chk({v.name, " pulse_end"}, {30'd0, LoadValid, Fault}, 32'd0);
    $display("txn %-14s stall=%0d beats=%0d fault=%0b valid=%0b rdata=%h",
             v.name, stall_cnt, beat_n, r_fault, r_valid, r_data);
  endtask

  initial begin
    int en_cnt, st_cnt;
    bit seen_fault;
    logic [31:0] f_data;
    logic        f_valid;

    RST = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0;
    DataAddress = '0; WriteData = '0;

    // name rd wr f3 addr wd waits stall nbeats fault valid rdata a1 s1 d1 a2 s2 d2
    add("sw",      0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 2, 1, 0, 0, 32'h0,
        32'h100, 4'b1111, 32'hDEADBEEF, 0, 0, 0);
    add("lb",      1, 0, 3'b000, 32'h203, 32'h0, 0, 2, 1, 0, 1, 32'hFFFFFF80,
        32'h200, 4'b0000, 32'h0, 0, 0, 0);
    add("lbu",     1, 0, 3'b100, 32'h203, 32'h0, 0, 2, 1, 0, 1, 32'h00000080,
        32'h200, 4'b0000, 32'h0, 0, 0, 0);
    add("sh_wait2",0, 1, 3'b001, 32'h102, 32'h00001234, 2, 4, 1, 0, 0, 32'h0,
        32'h100, 4'b1100, 32'h12340000, 0, 0, 0);
    add("lw_wait1",1, 0, 3'b010, 32'h100, 32'h0, 1, 3, 1, 0, 1, 32'h44332211,
        32'h100, 4'b0000, 32'h0, 0, 0, 0);
    add("lh_neg",  1, 0, 3'b001, 32'h106, 32'h0, 0, 2, 1, 0, 1, 32'hFFFF8877,
        32'h104, 4'b0000, 32'h0, 0, 0, 0);
    add("lhu",     1, 0, 3'b101, 32'h106, 32'h0, 0, 2, 1, 0, 1, 32'h00008877,
        32'h104, 4'b0000, 32'h0, 0, 0, 0);
    add("lb_pos",  1, 0, 3'b000, 32'h101, 32'h0, 0, 2, 1, 0, 1, 32'h00000022,
        32'h100, 4'b0000, 32'h0, 0, 0, 0);
    add("sb",      0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 2, 1, 0, 0, 32'h0,
        32'h100, 4'b1000, 32'hA5000000, 0, 0, 0);
    add("rd_and_wr",1, 1, 3'b010, 32'h100, 32'h0, 0, 1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    add("ld_f3_011",1, 0, 3'b011, 32'h100, 32'h0, 0, 1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    add("ld_f3_110",1, 0, 3'b110, 32'h100, 32'h0, 0, 1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    add("st_f3_100",0, 1, 3'b100, 32'h100, 32'h0, 0, 1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
    add("lw_split",1, 0, 3'b010, 32'h101, 32'h0, 0, 3, 2, 0, 1, 32'h55443322,
        32'h100, 4'b0000, 32'h0, 32'h104, 4'b0000, 32'h0);
    add("lw_wrap", 1, 0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, 3, 2, 0, 1, 32'h1100BBAA,
        32'hFFFFFFFC, 4'b0000, 32'h0, 32'h00000000, 4'b0000, 32'h0);
    add("sh_split",0, 1, 3'b001, 32'h103, 32'h0000CAFE, 1, 5, 2, 0, 0, 32'h0,
        32'h100, 4'b1000, 32'hFE000000, 32'h104, 4'b0001, 32'h000000CA);
    add("lhu_off1",1, 0, 3'b101, 32'h101, 32'h0, 0, 2, 1, 0, 1, 32'h00003322,
        32'h100, 4'b0000, 32'h0, 0, 0, 0);
`else
    add("lw_mis",  1, 0, 3'b010, 32'h101, 32'h0, 0, 1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    add("lw_mis_hi",1, 0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, 1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    add("sh_mis",  0, 1, 3'b001, 32'h103, 32'h0000CAFE, 0, 1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    add("lhu_off1",1, 0, 3'b101, 32'h101, 32'h0, 0, 1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
`endif

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst mem_en",    32'(mem_en), 32'd0);
    chk("rst mem_we",    32'(mem_we), 32'd0);
    chk("rst mem_addr",  mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst outputs",   {29'd0, LoadValid, Fault, Stall}, 32'd0);
    chk("rst read_data", ReadData, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Watchdog: memory never ready, TIMEOUT_CYCLES=4
    beat_n = 0; cur_waits = 1000;
    MemRead = 1'b1; Funct3 = 3'b010; DataAddress = 32'h100;
    #1;
    st_cnt = Stall ? 1 : 0;
    en_cnt = 0; seen_fault = 1'b0; f_data = 32'hFFFFFFFF; f_valid = 1'b1;
    for (int c = 0; c < 20 && !seen_fault; c++) begin
      @(negedge CLK);
      if (mem_en) en_cnt++;
      if (Stall) st_cnt++;
      if (Fault) begin
        seen_fault = 1'b1;
        f_data  = ReadData;
        f_valid = LoadValid;
        chk("timeout mem_en_in_resp", 32'(mem_en), 32'd0);
        chk("timeout stall_in_resp", 32'(Stall), 32'd0);
      end
    end
    MemRead = 1'b0;
    chk("timeout fault_seen", 32'(seen_fault), 32'd1);
    chk("timeout mem_en_cycles", en_cnt, 4);
    chk("timeout stall_cycles", st_cnt, 5);
    chk("timeout read_data", f_data, 32'd0);
    chk("timeout load_valid", 32'(f_valid), 32'd0);
    @(negedge CLK);
    chk("timeout fault_pulse", {30'd0, Fault, mem_en}, 32'd0);
    $display("txn %-14s mem_en_cycles=%0d stall=%0d fault=%0b", "timeout", en_cnt, st_cnt, seen_fault);

    // Reset asserted while BEAT1 is waiting
    beat_n = 0; cur_waits = 1000;
    MemRead = 1'b1; Funct3 = 3'b010; DataAddress = 32'h104;
    @(negedge CLK);
    chk("rst_mid mem_en_beat1", 32'(mem_en), 32'd1);
    RST = 1'b1; MemRead = 1'b0;
    @(negedge CLK);
    chk("rst_mid mem_en_dropped", 32'(mem_en), 32'd0);
    chk("rst_mid no_resp", {29'd0, LoadValid, Fault, Stall}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid no_resp_after", {30'd0, LoadValid, Fault}, 32'd0);
    $display("txn %-14s reset during beat1", "rst_mid");
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage initiator for the word-organised data memory port. Accepts load/store requests from the pipeline, issues aligned word transactions with byte strobes, and merges, shifts and extends the returned data.
- Stalls the pipeline while a transaction is in flight.
- Splits misaligned accesses into two aligned beats when the optional feature is enabled.
- Bounds every beat with a wait-state watchdog.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT_CYCLES, 16, maximum cycles a beat may wait for mem_ready before aborting. Must be at least 1.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- MemRead  in  1  load request from the pipeline
- MemWrite  in  1  store request from the pipeline
- Funct3  in  3  access type: 000 b, 001 h, 010 w, 100 bu, 101 hu
- DataAddress  in  XLEN  byte address
- WriteData  in  XLEN  store data, right-aligned
- ReadData  out  XLEN  extended load result
- LoadValid  out  1  ReadData valid (load completed)
- Stall  out  1  hold the pipeline
- Fault  out  1  access aborted (illegal, misaligned or timeout)
- mem_en  out  1  memory transaction request
- mem_we  out  1  write enable
- mem_addr  out  XLEN  word address, bits[1:0] always 0
- mem_wdata  out  XLEN  lane-shifted store data
- mem_wstrb  out  4  byte-lane strobes
- mem_rdata  in  XLEN  memory read word, valid when mem_ready=1
- mem_ready  in  1  beat completes this cycle

Behaviour:
- Reset: state IDLE; ReadData, LoadValid, Fault, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, the merge buffer and the watchdog all 0.
- RST mid-operation: abort immediately, mem_en=0 the next cycle. No retry; a completed first beat of a split store stays in memory.
- States:
  - IDLE → BEAT1 on a legal request.
  - IDLE → RESP with Fault on an illegal request.
  - BEAT1 → BEAT2 on mem_ready when split; BEAT1 → RESP on mem_ready when not split.
  - BEAT2 → RESP on mem_ready.
  - RESP → IDLE unconditionally.
- Stall:
  - In IDLE: combinational, equal to MemRead|MemWrite.
  - In BEAT1/BEAT2: 1.
  - In RESP: 0. The pipeline advances in RESP; the request still visible in RESP is never re-accepted.
- Request capture in IDLE: register address, Funct3, direction and WriteData.
- Illegal request (no memory access issued):
  - MemRead and MemWrite both 1.
  - Load Funct3 of 011, 110 or 111.
  - Store Funct3 above 010.
- Beat signals: mem_en, mem_we, mem_addr, mem_wdata and mem_wstrb are registered, stable throughout a beat, and held until mem_ready.
- Strobes and data: offset o = addr[1:0]; size s = 1, 2 or 4.
  - Beat 1: mem_addr = addr & ~3; mem_wstrb = ((1<<s)-1) << o, truncated to 4 bits; mem_wdata = WriteData << 8o.
  - Beat 2 (only when o+s > 4): mem_addr = (addr & ~3) + 4, wrapping modulo 2^XLEN; strobes are the remaining low lanes; data holds the remaining upper bytes.
- Loads: on each beat's mem_ready, capture mem_rdata into the merge buffer. In RESP, ReadData holds the bytes reassembled and sign-extended (b, h) or zero-extended (bu, hu).
- RESP outputs (one-cycle pulses):
  - LoadValid=1 for a completed load.
  - LoadValid=0 for a store or any Fault.
  - Fault=1 for an aborted access; ReadData=0 on Fault.
- Watchdog: counts cycles in BEAT1/BEAT2 with mem_ready=0 and clears at each beat start. When it reaches TIMEOUT_CYCLES: drop mem_en, go to RESP with Fault=1.
- mem_ready outside BEAT1/BEAT2 is ignored.
- Latency with zero-wait memory: aligned access 3 cycles from accept to the RESP pulse; split access 4 cycles. Each wait state adds 1 cycle.

Optional Feature:
- LSU_MISALIGN_SPLIT_EN defined: misaligned accesses (o+s > 4) are split into two beats as above.
- LSU_MISALIGN_SPLIT_EN undefined: any access with o not a multiple of s is illegal. The unit goes IDLE → RESP with Fault=1, issues no memory beat, and has no BEAT2 state.

Test Plan:
- sw 0xDEADBEEF to 0x100, zero-wait memory → one beat: mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; Stall high 2 cycles; RESP LoadValid=0, Fault=0.
- lb from 0x203, memory word 0x80xxxxxx → wstrb=0000, mem_we=0; ReadData=0xFFFFFF80. Same access as lbu → ReadData=0x00000080.
- sh 0x1234 to 0x102 with 2 wait states → wstrb=1100, wdata=0x12340000; Stall high for 4 cycles; RESP in the 5th cycle.
- lw from 0x101 (split enabled), word 0x100=0x44332211, word 0x104=0x88776655 → beats at 0x100 then 0x104; ReadData=0x55443322. With split disabled → no beat, Fault=1.
- lw from 0xFFFFFFFE (split enabled) → second beat at mem_addr=0x00000000 (wrap).
- mem_ready held 0 with TIMEOUT_CYCLES=4 → mem_en drops after 4 wait cycles; Fault=1 for one cycle; then IDLE. RST asserted in BEAT1 → next cycle mem_en=0, state IDLE, no RESP pulse.
